// File: rtl/debounce_array.sv
// debounce_array
//   Multi-channel pushbutton/switch conditioner. Each channel synchronises its
//   raw input, accepts a new level only after DB_COUNT consecutive samples
//   that disagree with the current level, and emits one-cycle rise/fall strobes.
//   An optional per-channel auto-repeat strobe fires on the press. If the
//   channel has repeat enabled, it also fires REPEAT_DELAY cycles later and then
//   every REPEAT_PERIOD cycles while the level stays high.
//
// Ports
//   clk_in      : system clock (only clock)
//   rst_in_n    : synchronous active-low reset
//   noisy_in    : raw asynchronous inputs, one bit per channel
//   clean_out   : debounced level
//   rise_out    : one-cycle strobe on each 0->1 change of clean_out
//   fall_out    : one-cycle strobe on each 1->0 change of clean_out
//   repeat_out  : press strobe plus auto-repeat strobes
//
// The per-channel repeat FSM state is held in state_q so checkers can bind
// to it directly.
module debounce_array #(
    parameter int                  CHANNELS      = 5,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  DB_COUNT      = 650_000,
    parameter int                  REPEAT_DELAY  = 32_500_000,
    parameter int                  REPEAT_PERIOD = 6_500_000,
    parameter logic [CHANNELS-1:0] REPEAT_EN     = '1
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic [CHANNELS-1:0] repeat_out
);

    localparam int DBW     = $clog2(DB_COUNT + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW     = $clog2(REP_MAX + 1);

    // Terminal values: the count "would reach" its target on the cycle it
    // currently holds target-1.
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
    localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);
    localparam logic [RPW-1:0] RP_ONE  = RPW'(1);

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_PERIOD = 2'd2
    } rep_state_e;

    logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_d   [CHANNELS];
    logic [DBW-1:0]         db_cnt_q [CHANNELS];
    logic [DBW-1:0]         db_cnt_d [CHANNELS];
    logic [RPW-1:0]         rep_cnt_q[CHANNELS];
    logic [RPW-1:0]         rep_cnt_d[CHANNELS];
    rep_state_e             state_q  [CHANNELS];
    rep_state_e             state_d  [CHANNELS];

    logic [CHANNELS-1:0] samp;
    logic [CHANNELS-1:0] clean_q, clean_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] rep_q, rep_d;

    // Synchroniser shift registers; the oldest stage is the usable sample.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], noisy_in[i]};
            samp[i]   = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce: any sample agreeing with the current level restarts the run.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (samp[i] == clean_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                clean_d[i]  = samp[i];
                rise_d[i]   = samp[i];
                fall_d[i]   = ~samp[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
    end

    // Repeat FSM. It reacts to the combinational rise/fall so that the press
    // strobe lands in the same registered cycle as rise_out, and a fall
    // suppresses any repeat pulse that would coincide with it.
    always_comb begin
        rep_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            case (state_q[i])
                RP_IDLE: begin
                    if (rise_d[i]) begin
                        rep_d[i]     = 1'b1;
                        rep_cnt_d[i] = '0;
                        if (REPEAT_EN[i]) begin
                            state_d[i] = RP_DELAY;
                        end
                    end
                end
                RP_DELAY: begin
                    if (fall_d[i]) begin
                        state_d[i]   = RP_IDLE;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == RD_LAST) begin
                        rep_d[i]     = 1'b1;
                        rep_cnt_d[i] = '0;
                        state_d[i]   = RP_PERIOD;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RP_ONE;
                    end
                end
                RP_PERIOD: begin
                    if (fall_d[i]) begin
                        state_d[i]   = RP_IDLE;
                        rep_cnt_d[i] = '0;
                    end else if (rep_cnt_q[i] == RP_LAST) begin
                        rep_d[i]     = 1'b1;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + RP_ONE;
                    end
                end
                default: begin
                    state_d[i]   = RP_IDLE;
                    rep_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]    <= '0;
                db_cnt_q[i]  <= '0;
                rep_cnt_q[i] <= '0;
                state_q[i]   <= RP_IDLE;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            rep_q   <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]    <= sync_d[i];
                db_cnt_q[i]  <= db_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rep_q   <= rep_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign repeat_out = rep_q;

endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array
//   Directed plus randomised stimulus for debounce_array with small timing
//   parameters. A reference model tracks the expected outputs every cycle:
//   the debouncer is modelled as "the last DB samples since the previous
//   change all disagree with the level", and the repeat strobe is computed
//   arithmetically from the press time.
module tb_debounce_array;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [CH-1:0] EN = 2'b01;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] noisy = '0;
    logic [CH-1:0] clean, rise, fall, rep;

    always #5 clk = ~clk;

    debounce_array #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .DB_COUNT     (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_EN    (EN)
    ) dut (
        .clk_in    (clk),
        .rst_in_n  (rst_n),
        .noisy_in  (noisy),
        .clean_out (clean),
        .rise_out  (rise),
        .fall_out  (fall),
        .repeat_out(rep)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    logic [CH-1:0] m_pipe [$];   // inputs in flight through the synchroniser
    logic [CH-1:0] s_hist [$];   // synchronised samples since reset
    int            last_t [CH];  // s_hist index of the last level change
    int            m_press[CH];  // cycle of the last press strobe
    logic [CH-1:0] m_clean, m_rise, m_fall, m_rep;

    function automatic void model_reset();
        m_pipe.delete();
        for (int k = 0; k < SS; k++) m_pipe.push_back('0);
        s_hist.delete();
        for (int c = 0; c < CH; c++) begin
            last_t[c]  = -1;
            m_press[c] = 0;
        end
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_rep   = '0;
    endfunction

    function automatic void model_edge(input logic r, input logic [CH-1:0] nz, input int now);
        logic [CH-1:0] s;
        int n;
        int d;
        bit ok;
        if (!r) begin
            model_reset();
            return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(nz);
        s_hist.push_back(s);
        n = s_hist.size() - 1;
        m_rise = '0;
        m_fall = '0;
        m_rep  = '0;
        for (int c = 0; c < CH; c++) begin
            if (n - last_t[c] >= DB) begin
                ok = 1'b1;
                for (int k = n - DB + 1; k <= n; k++)
                    if (s_hist[k][c] == m_clean[c]) ok = 1'b0;
                if (ok) begin
                    m_clean[c] = ~m_clean[c];
                    m_rise[c]  = m_clean[c];
                    m_fall[c]  = ~m_clean[c];
                    last_t[c]  = n;
                    if (m_clean[c]) m_press[c] = now;
                end
            end
            if (m_rise[c]) begin
                m_rep[c] = 1'b1;
            end else if (EN[c] && m_clean[c]) begin
                d = now - m_press[c];
                if (d >= RD && ((d - RD) % RP) == 0) m_rep[c] = 1'b1;
            end
        end
    endfunction

    // ---------------- checkers ----------------
    task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: capture the inputs the DUT samples, advance the model, then
    // compare just after the edge.
    task automatic step();
        logic          r;
        logic [CH-1:0] nz;
        r  = rst_n;
        nz = noisy;
        @(posedge clk);
        cyc++;
        model_edge(r, nz, cyc);
        #1;
        check_vec("clean", clean, m_clean);
        check_vec("rise", rise, m_rise);
        check_vec("fall", fall, m_fall);
        check_vec("repeat", rep, m_rep);
        check_vec("rise_fall_excl", rise & fall, '0);
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Steps until rise_out[ch]; returns the step count, or -1 after the limit.
    task automatic wait_rise(input int ch, input int limit, output int n, output int reps_before);
        n = -1;
        reps_before = 0;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (rise[ch]) begin
                n = k;
                break;
            end
            if (rep[ch]) reps_before++;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    int exp_q [$];
    int obs_q [$];
    int n, t0, cnt_a, cnt_b, reps_before;
    bit seen;

    initial begin
        model_reset();

        // Reset held with both buttons pressed.
        rst_n = 1'b0;
        noisy = 2'b11;
        step_n(5);
        check_vec("reset_outputs", clean | rise | fall | rep, '0);

        // Release: press strobe after SYNC_STAGES + DB_COUNT cycles, then auto-repeat.
        rst_n = 1'b1;
        wait_rise(0, 20, n, reps_before);
        check_int("reset_release_latency", n, SS + DB);
        check_int("reset_release_rep_strobe", int'(rep[0]), 1);
        obs_q.delete();
        if (rep[0]) obs_q.push_back(0);
        t0 = cyc;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (rep[0]) obs_q.push_back(cyc - t0);
        end
        exp_q = '{0, 10, 13, 16, 19, 22, 25, 28};
        check_int("auto_repeat_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check_int("auto_repeat_offset", obs_q[k], exp_q[k]);

        // Release: one fall strobe, no repeat from the fall onward.
        noisy = 2'b00;
        cnt_a = 0;
        cnt_b = 0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fall[0]) begin
                cnt_a++;
                seen = 1'b1;
            end
            if (seen && rep[0]) cnt_b++;
        end
        check_int("release_fall_count", cnt_a, 1);
        check_int("release_reps_after_fall", cnt_b, 0);

        // Clean press from idle.
        noisy[0] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        n = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (clean[0] && n < 0) n = k;
            if (rise[0]) cnt_a++;
            if (fall[0]) cnt_b++;
        end
        check_int("press_latency", n, SS + DB);
        check_int("press_rise_count", cnt_a, 1);
        check_int("press_fall_count", cnt_b, 0);
        noisy = 2'b00;
        step_n(15);

        // Bounce rejection: 1,1,1,0 repeating never builds a full run.
        cnt_a = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                noisy[0] = (k != 3);
                step();
                if (clean[0] || rise[0] || fall[0] || rep[0]) cnt_a++;
            end
        end
        check_int("bounce_activity", cnt_a, 0);
        noisy[0] = 1'b1;
        wait_rise(0, 20, n, reps_before);
        check_int("bounce_then_hold_latency", n, SS + DB);
        noisy = 2'b00;
        step_n(15);

        // Channel 1 (repeat disabled) held while channel 0 bounces randomly.
        noisy[1] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            noisy[0] = 1'($urandom_range(0, 1));
            step();
            if (rep[1]) cnt_a++;
            if (rep[1] != rise[1]) cnt_b++;
        end
        check_int("ch1_repeat_count", cnt_a, 1);
        check_int("ch1_repeat_vs_rise", cnt_b, 0);
        noisy = 2'b00;
        step_n(15);

        // Reset during channel 0's DELAY with the button held.
        noisy = 2'b01;
        wait_rise(0, 20, n, reps_before);
        check_int("midreset_first_press", n, SS + DB);
        step_n(5);
        rst_n = 1'b0;
        step();
        check_vec("midreset_outputs", clean | rise | fall | rep, '0);
        rst_n = 1'b1;
        wait_rise(0, 20, n, reps_before);
        check_int("midreset_repress_latency", n, SS + DB);
        check_int("midreset_stale_reps", reps_before, 0);
        check_int("midreset_press_strobe", int'(rep[0]), 1);

        // Random segments of held values with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            noisy = CH'($urandom_range(0, (1 << CH) - 1));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step_n($urandom_range(1, 25));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
